// File: rtl/jt89_sched_pkg.sv
// Shared types and constants for the jt89 write scheduler.
package jt89_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RL_LO = 3'd1,
        RL_HI = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4
    } state_t;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    localparam int unsigned LATCH_BIT = 7;

endpackage

// File: rtl/jt89_wr_fifo.sv
// Synchronous FIFO for requester A; push is ignored when full, pop when empty,
// and a simultaneous push+pop leaves the count unchanged.
module jt89_wr_fifo #(
    parameter int unsigned AW = 2,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);
    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + AW'(1);
            if (do_pop)  rp <= rp + AW'(1);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/jt89_wr_sched.sv
// jt89 write scheduler: arbitrates CPU FIFO (A) and player stream (B) into
// spaced wr_n pulses, re-issuing a latch byte when requesters interleave.
// Optional drop counter enabled by defining PSG_SCHED_DROPCNT_EN.
module jt89_wr_sched
    import jt89_sched_pkg::*;
#(
    parameter int unsigned FIFO_AW = 2,
    parameter int unsigned WR_GAP  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_wr,
    input  logic [7:0] a_din,
    output logic       a_full,
    output logic       a_ovf,
    input  logic       b_valid,
    input  logic [7:0] b_data,
    output logic       b_ready,
    output logic       psg_wr_n,
    output logic [7:0] psg_din,
    output logic       busy,
    output logic [7:0] drop_cnt
);
    localparam int unsigned CW = $clog2(WR_GAP + 1);

    state_t        state;
    logic [CW-1:0] gap;
    logic [7:0]    byte_r;
    logic [7:0]    shadow [2];
    logic [1:0]    shadow_v;
    logic          owner;
    logic          owner_v;
    logic          rr;
    logic          grantee_r;

    logic          a_empty;
    logic [7:0]    a_dout;
    logic          a_drop;
    logic          grant_a;
    logic          grant_b;
    logic          gnt_id;
    logic [7:0]    sel_byte;
    logic          relatch;
    logic          gap_done;

    assign a_drop = a_wr && a_full;
    assign busy   = (state != IDLE) || !a_empty;

    jt89_wr_fifo #(.AW(FIFO_AW), .DW(8)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (a_wr),
        .din   (a_din),
        .pop   (grant_a),
        .dout  (a_dout),
        .full  (a_full),
        .empty (a_empty)
    );

    // Arbitration and relatch decision, only meaningful in IDLE
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state == IDLE) begin
            if (!a_empty && b_valid) begin
                grant_a = (rr == REQ_A);
                grant_b = (rr == REQ_B);
            end else begin
                grant_a = !a_empty;
                grant_b = b_valid;
            end
        end
        gnt_id   = grant_b ? REQ_B : REQ_A;
        sel_byte = grant_b ? b_data : a_dout;
        relatch  = !sel_byte[LATCH_BIT] && owner_v && (owner != gnt_id) && shadow_v[gnt_id];
        gap_done = (gap == CW'(WR_GAP - 1));
    end

    // b_ready follows the grant by one cycle; the player holds b_data until then
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gap       <= '0;
            byte_r    <= '0;
            psg_wr_n  <= 1'b1;
            psg_din   <= '0;
            b_ready   <= 1'b0;
            a_ovf     <= 1'b0;
            shadow[0] <= '0;
            shadow[1] <= '0;
            shadow_v  <= '0;
            owner     <= REQ_A;
            owner_v   <= 1'b0;
            rr        <= REQ_A;
            grantee_r <= REQ_A;
        end else begin
            b_ready <= 1'b0;
            if (a_drop) a_ovf <= 1'b1;
            case (state)
                IDLE: begin
                    if (grant_a || grant_b) begin
                        rr        <= ~gnt_id;
                        grantee_r <= gnt_id;
                        byte_r    <= sel_byte;
                        b_ready   <= grant_b;
                        gap       <= '0;
                        psg_wr_n  <= 1'b0;
                        if (relatch) begin
                            state   <= RL_LO;
                            psg_din <= shadow[gnt_id];
                        end else begin
                            state   <= WR_LO;
                            psg_din <= sel_byte;
                            owner   <= gnt_id;
                            owner_v <= 1'b1;
                            if (sel_byte[LATCH_BIT]) begin
                                shadow[gnt_id]   <= sel_byte;
                                shadow_v[gnt_id] <= 1'b1;
                            end
                        end
                    end
                end
                RL_LO: begin
                    gap <= gap + CW'(1);
                    if (gap_done) begin
                        state    <= RL_HI;
                        gap      <= '0;
                        psg_wr_n <= 1'b1;
                    end
                end
                RL_HI: begin
                    gap <= gap + CW'(1);
                    if (gap_done) begin
                        state    <= WR_LO;
                        gap      <= '0;
                        psg_wr_n <= 1'b0;
                        psg_din  <= byte_r;
                        owner    <= grantee_r;
                        owner_v  <= 1'b1;
                        if (byte_r[LATCH_BIT]) begin
                            shadow[grantee_r]   <= byte_r;
                            shadow_v[grantee_r] <= 1'b1;
                        end
                    end
                end
                WR_LO: begin
                    gap <= gap + CW'(1);
                    if (gap_done) begin
                        state    <= WR_HI;
                        gap      <= '0;
                        psg_wr_n <= 1'b1;
                    end
                end
                WR_HI: begin
                    gap <= gap + CW'(1);
                    if (gap_done) begin
                        state <= IDLE;
                        gap   <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    gap      <= '0;
                    psg_wr_n <= 1'b1;
                end
            endcase
        end
    end

`ifdef PSG_SCHED_DROPCNT_EN
    // Saturating count of dropped CPU writes
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (a_drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`else
    assign drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_jt89_wr_sched.sv
// Bench for jt89_wr_sched: directed stimulus, expected PSG bytes queued at issue
// and checked by a monitor on each psg_wr_n falling edge.
module tb_jt89_wr_sched;
    import jt89_sched_pkg::*;

    localparam int unsigned WR_GAP = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_wr;
    logic [7:0] a_din;
    logic       a_full;
    logic       a_ovf;
    logic       b_valid;
    logic [7:0] b_data;
    logic       b_ready;
    logic       psg_wr_n;
    logic [7:0] psg_din;
    logic       busy;
    logic [7:0] drop_cnt;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int n_exp  = 0;
    logic [7:0] exp_q [$];

    jt89_wr_sched #(.FIFO_AW(2), .WR_GAP(WR_GAP)) dut (
        .clk      (clk),
        .rst      (rst),
        .a_wr     (a_wr),
        .a_din    (a_din),
        .a_full   (a_full),
        .a_ovf    (a_ovf),
        .b_valid  (b_valid),
        .b_data   (b_data),
        .b_ready  (b_ready),
        .psg_wr_n (psg_wr_n),
        .psg_din  (psg_din),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_byte(input logic [7:0] v);
        exp_q.push_back(v);
        n_exp++;
    endtask

    task automatic a_send(input logic [7:0] v);
        a_wr  = 1'b1;
        a_din = v;
        tick();
        a_wr  = 1'b0;
    endtask

    task automatic b_send(input logic [7:0] v);
        bit done = 0;
        b_valid = 1'b1;
        b_data  = v;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (b_ready) done = 1;
            tick();
        end
        b_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL b_send timeout: data %02h never accepted", v);
        end
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1;
        end
        tick();
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL wait_idle timeout: busy %0b expected 0", busy);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " psg_wr_n"}, 8'(psg_wr_n), 8'h01);
        chk({tag, " psg_din"},  psg_din,      8'h00);
        chk({tag, " a_full"},   8'(a_full),   8'h00);
        chk({tag, " a_ovf"},    8'(a_ovf),    8'h00);
        chk({tag, " b_ready"},  8'(b_ready),  8'h00);
        chk({tag, " busy"},     8'(busy),     8'h00);
        chk({tag, " drop_cnt"}, drop_cnt,     8'h00);
    endtask

    // Scoreboard monitor: byte at each falling edge, low width, din held into high phase, b_ready width
    logic       prev_wrn = 1'b1;
    logic       prev_brdy = 1'b0;
    logic       in_pulse = 1'b0;
    int         lo_cnt = 0;
    logic [7:0] cur_din = '0;

    always @(negedge clk) begin
        if (rst) begin
            in_pulse = 1'b0;
            lo_cnt   = 0;
        end else begin
            if (prev_wrn && !psg_wr_n) begin
                pulses++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected write: got %02h expected none", psg_din);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    checks--;
                    chk("psg_din byte", psg_din, e);
                end
                in_pulse = 1'b1;
                lo_cnt   = 1;
                cur_din  = psg_din;
            end else if (!psg_wr_n) begin
                lo_cnt++;
            end else if (!prev_wrn && in_pulse) begin
                chk("low width", 8'(lo_cnt), 8'(WR_GAP));
                chk("din held high", psg_din, cur_din);
                in_pulse = 1'b0;
            end
            if (b_ready) chk("b_ready prev cycle", 8'(prev_brdy), 8'h00);
        end
        prev_wrn  = psg_wr_n;
        prev_brdy = b_ready;
    end

    logic [6:0] t1_wrn;
    logic [6:0] t1_busy;

    initial begin
        rst     = 1'b1;
        a_wr    = 1'b0;
        a_din   = '0;
        b_valid = 1'b0;
        b_data  = '0;
        repeat (3) tick();
        @(negedge clk);
        chk_reset_vals("reset");
        tick();
        rst = 1'b0;

        // Test 1: single A write, cycle-exact pulse shape
        t1_wrn  = 7'b1110011;
        t1_busy = 7'b0111110;
        expect_byte(8'h9F);
        a_wr  = 1'b1;
        a_din = 8'h9F;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            chk($sformatf("t1 wr_n c%0d", c), 8'(psg_wr_n), 8'(t1_wrn[c]));
            chk($sformatf("t1 busy c%0d", c), 8'(busy), 8'(t1_busy[c]));
            if (c >= 2 && c <= 5) chk($sformatf("t1 din c%0d", c), psg_din, 8'h9F);
            tick();
            a_wr = 1'b0;
        end

        // Test 2: overflow while busy; fifth queued write is dropped
        expect_byte(8'h90);
        for (int k = 0; k < 4; k++) expect_byte(8'(8'h91 + k));
        a_send(8'h90);
        tick();
        for (int k = 0; k < 5; k++) begin
            a_wr  = 1'b1;
            a_din = 8'(8'h91 + k);
            if (k == 4) begin
                @(negedge clk);
                chk("t2 a_full", 8'(a_full), 8'h01);
            end
            tick();
        end
        a_wr = 1'b0;
        @(negedge clk);
        chk("t2 a_ovf", 8'(a_ovf), 8'h01);
`ifdef PSG_SCHED_DROPCNT_EN
        chk("t2 drop_cnt", drop_cnt, 8'h01);
`else
        chk("t2 drop_cnt", drop_cnt, 8'h00);
`endif
        tick();
        wait_idle();
        chk("t2 a_ovf sticky", 8'(a_ovf), 8'h01);

        // Test 3: interleaved requesters force a relatch of A's 8A before 12
        expect_byte(8'h8A);
        expect_byte(8'hC5);
        expect_byte(8'h8A);
        expect_byte(8'h12);
        a_send(8'h8A);
        wait_idle();
        b_send(8'hC5);
        wait_idle();
        a_send(8'h12);
        wait_idle();

        // Test 4: both pending continuously -> alternating grants
        for (int k = 0; k < 4; k++) begin
            expect_byte(8'(8'h90 + k));
            expect_byte(8'(8'hB0 + k));
        end
        fork
            begin
                for (int k = 0; k < 4; k++) a_send(8'(8'h90 + k));
            end
            begin
                tick();
                tick();
                for (int k = 0; k < 4; k++) b_send(8'(8'hB0 + k));
            end
        join
        wait_idle();

        // Test 6: reset during WR_LO drops everything in flight
        expect_byte(8'hA1);
        a_send(8'hA1);
        a_send(8'hA2);
        begin
            bit seen = 0;
            for (int i = 0; i < 50 && !seen; i++) begin
                @(negedge clk);
                if (!psg_wr_n) seen = 1;
            end
            chk("t6 reached WR_LO", 8'(seen), 8'h01);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("t6 after rst");
        tick();

        // Test 5: first data byte after reset from B, no relatch
        expect_byte(8'h05);
        b_send(8'h05);
        wait_idle();
        repeat (10) tick();

        chk("queue drained", 8'(exp_q.size()), 8'h00);
        chk("pulse count", 8'(pulses), 8'(n_exp));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: sim time %0t limit 200000", $time);
        $fatal(1);
    end

endmodule
